// File: rtl/gf32_mul_share_server_pkg.sv
`default_nettype none
// =====================================================================
// gf32_mul_share_server_pkg : field names, requester IDs, tag FIFO depth
// and byte-lane GF(2^8) / GF(251) multiply functions.  Rev 1.0
// =====================================================================
package gf32_mul_share_server_pkg;

   localparam string FIELD_GF256 = "GF256";
   localparam string FIELD_P251  = "P251";

   localparam int TAG_DEPTH = 2;
   localparam int TAG_PTR_W = $clog2(TAG_DEPTH);
   localparam int TAG_CNT_W = $clog2(TAG_DEPTH + 1);

   typedef enum logic {
      REQ_0 = 1'b0,
      REQ_1 = 1'b1
   } req_id_e;

   // Carry-less product reduced by the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf256_mul8(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ (15'(a) << i);
      end
      for (int i = 14; i >= 8; i--) begin
         if (p[i]) p = p ^ (15'h11B << (i - 8));
      end
      return p[7:0];
   endfunction

   function automatic logic [7:0] gf251_mul8(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = ({8'd0, a} * {8'd0, b}) % 16'd251;
      return p[7:0];
   endfunction

   function automatic logic [31:0] gf_mul_32(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         r[8*l +: 8] = gf256_mul8(a[8*l +: 8], b[8*l +: 8]);
      end
      return r;
   endfunction

   function automatic logic [31:0] gf251_mul_32(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         r[8*l +: 8] = gf251_mul8(a[8*l +: 8], b[8*l +: 8]);
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gf32_mul_core.sv
`default_nettype none
// =====================================================================
// gf32_mul_core : fixed-latency pipelined 4-lane field multiplier.
// Rev 1.0
// =====================================================================
module gf32_mul_core
   import gf32_mul_share_server_pkg::*;
#(
   parameter string FIELD   = FIELD_P251,
   parameter int    MUL_LAT = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [31:0] i_x,
   input  logic [31:0] i_y,
   output logic        o_done,
   output logic [31:0] o_res
);

   logic [31:0]        w_prod;
   logic [MUL_LAT-1:0] vld_q;
   logic [31:0]        res_q [MUL_LAT];

   generate
      if (FIELD == FIELD_GF256) begin : g_gf256
         assign w_prod = gf_mul_32(i_x, i_y);
      end else begin : g_p251
         assign w_prod = gf251_mul_32(i_x, i_y);
      end
   endgenerate

   // Product is formed in the first stage; later stages only delay it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q <= '0;
         res_q <= '{default: '0};
      end else begin
         vld_q[0] <= i_start;
         res_q[0] <= w_prod;
         for (int s = 1; s < MUL_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            res_q[s] <= res_q[s-1];
         end
      end
   end

   assign o_done = vld_q[MUL_LAT-1];
   assign o_res  = res_q[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/gf32_mul_share_server.sv
`default_nettype none
// =====================================================================
// gf32_mul_share_server : two requesters sharing one pipelined GF multiplier
// with round-robin arbitration and an in-order result tag FIFO.  Rev 1.0
// =====================================================================
module gf32_mul_share_server
   import gf32_mul_share_server_pkg::*;
#(
   parameter string FIELD   = "P251",
   parameter int    MUL_LAT = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start_0,
   input  logic [31:0] i_x_0,
   input  logic [31:0] i_y_0,
   output logic [31:0] o_o_0,
   output logic        o_done_0,
   input  logic        i_start_1,
   input  logic [31:0] i_x_1,
   input  logic [31:0] i_y_1,
   output logic [31:0] o_o_1,
   output logic        o_done_1,
   output logic        o_err
);

   logic [1:0]           pending_q, pending_d;
   logic [1:0]           hold_v_q, hold_v_d;
   logic [31:0]          hold_x_q [2];
   logic [31:0]          hold_x_d [2];
   logic [31:0]          hold_y_q [2];
   logic [31:0]          hold_y_d [2];
   req_id_e              rr_q, rr_d;
   req_id_e              tag_q [TAG_DEPTH];
   req_id_e              tag_d [TAG_DEPTH];
   logic [TAG_PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [TAG_CNT_W-1:0] cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic [1:0]  w_start, w_pend, w_acc, w_viol, w_cand, w_done;
   logic [31:0] w_x [2];
   logic [31:0] w_y [2];
   req_id_e     w_gnt, w_lose;
   logic        w_contend, w_core_start, w_core_done, w_pop, w_push;
   logic [31:0] w_core_x, w_core_y, w_core_res;

   assign w_start = {i_start_1, i_start_0};
   assign w_x[0]  = i_x_0;
   assign w_x[1]  = i_x_1;
   assign w_y[0]  = i_y_0;
   assign w_y[1]  = i_y_1;

   // A requester whose result retires this cycle is no longer pending.
   always_comb begin
      w_pop  = w_core_done && (cnt_q != '0);
      w_done = '0;
      if (w_pop) w_done[tag_q[rd_q]] = 1'b1;
      w_pend = pending_q & ~w_done;
      w_acc  = w_start & ~w_pend & {2{~i_rst}};
      w_viol = w_start &  w_pend & {2{~i_rst}};
      w_cand = w_acc | hold_v_q;
   end

   always_comb begin
      w_contend    = &w_cand;
      w_core_start = |w_cand;
      w_gnt        = REQ_0;
      if (w_contend)      w_gnt = rr_q;
      else if (w_cand[1]) w_gnt = REQ_1;
      w_lose   = (w_gnt == REQ_0) ? REQ_1 : REQ_0;
      w_core_x = hold_v_q[w_gnt] ? hold_x_q[w_gnt] : w_x[w_gnt];
      w_core_y = hold_v_q[w_gnt] ? hold_y_q[w_gnt] : w_y[w_gnt];
   end

   always_comb begin
      pending_d = (pending_q & ~w_done) | w_acc;
      hold_v_d  = hold_v_q;
      hold_x_d  = hold_x_q;
      hold_y_d  = hold_y_q;
      rr_d      = rr_q;
      if (w_core_start) hold_v_d[w_gnt] = 1'b0;
      if (w_contend) begin
         rr_d = w_lose;
         if (!hold_v_q[w_lose]) begin
            hold_v_d[w_lose] = 1'b1;
            hold_x_d[w_lose] = w_x[w_lose];
            hold_y_d[w_lose] = w_y[w_lose];
         end
      end
   end

   always_comb begin
      tag_d  = tag_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      w_push = w_core_start && ((cnt_q != TAG_CNT_W'(TAG_DEPTH)) || w_pop);
      if (w_push) begin
         tag_d[wr_q] = w_gnt;
         wr_d        = wr_q + 1'b1;
      end
      if (w_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + TAG_CNT_W'(w_push) - TAG_CNT_W'(w_pop);
      err_d = err_q | (|w_viol) | (w_core_done && (cnt_q == '0));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pending_q <= '0;
         hold_v_q  <= '0;
         hold_x_q  <= '{default: '0};
         hold_y_q  <= '{default: '0};
         rr_q      <= REQ_0;
         tag_q     <= '{default: REQ_0};
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         hold_v_q  <= hold_v_d;
         hold_x_q  <= hold_x_d;
         hold_y_q  <= hold_y_d;
         rr_q      <= rr_d;
         tag_q     <= tag_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   gf32_mul_core #(
      .FIELD   (FIELD),
      .MUL_LAT (MUL_LAT)
   ) u_core (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (w_core_start),
      .i_x     (w_core_x),
      .i_y     (w_core_y),
      .o_done  (w_core_done),
      .o_res   (w_core_res)
   );

   assign o_done_0 = w_done[0];
   assign o_done_1 = w_done[1];
   assign o_o_0    = w_done[0] ? w_core_res : '0;
   assign o_o_1    = w_done[1] ? w_core_res : '0;
   assign o_err    = err_q;

endmodule
`default_nettype wire

// File: doc/gf32_mul_share_server.md
GF32_MUL_SHARE_SERVER -- requirements
Module: gf32_mul_share_server

Interface
REQ-001 SHALL have parameter FIELD, default "P251"; "GF256" selects the binary field, anything else selects GF(251).
REQ-002 SHALL have parameter MUL_LAT, default 2; it is the core start-to-done latency in cycles, minimum 1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_start_0, input, 1 bit: requester 0 one-cycle operation pulse.
REQ-006 SHALL have ports i_x_0 and i_y_0, input, 32 bits each: requester 0 operands, valid with i_start_0.
REQ-007 SHALL have port o_o_0, output, 32 bits: requester 0 product, valid with o_done_0.
REQ-008 SHALL have port o_done_0, output, 1 bit: requester 0 one-cycle completion pulse.
REQ-009 SHALL have ports i_start_1, i_x_1, i_y_1, o_o_1 and o_done_1, with identical widths and meanings, for requester 1.
REQ-010 SHALL have port o_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-011 SHALL serve two requesters, each limited to one outstanding operation, using one shared pipelined core that accepts one operation per cycle.
REQ-012 SHALL set pending_k on an accepted i_start_k and clear it in the cycle that o_done_k pulses.
REQ-013 SHALL, on i_start_k while pending_k=1, ignore the start and set o_err.
REQ-014 SHALL define candidate_k as an accepted i_start_k in the current cycle or a valid hold_k register; the two sources are mutually exclusive because a requester has one outstanding operation.
REQ-015 SHALL, with exactly one candidate, drive the core start and operands in the same cycle (zero added latency, bypass from the ports when not held).
REQ-016 SHALL, with two candidates, grant the requester selected by the round-robin pointer rr, and latch the loser's operands into hold_k (valid=1) if they are not already held.
REQ-017 SHALL initialise rr to requester 0 and toggle it after every contended grant; a held entry therefore issues on the next cycle, bounding wait to 1 cycle.
REQ-018 SHALL push the granted requester ID into a 2-entry in-order tag FIFO on each core start.
REQ-019 SHALL, on core done, pop the FIFO head k, pulse o_done_k for one cycle, and drive o_o_k with the core result in that cycle.
REQ-020 SHALL hold o_o_k at 0 in every cycle without o_done_k, and SHALL NOT assert o_done_0 and o_done_1 in the same cycle.
REQ-021 SHALL, on core done with an empty FIFO, discard the result and set o_err.
REQ-022 SHALL allow a FIFO push and pop in the same cycle; the FIFO never exceeds 2 entries under legal use.
REQ-023 SHALL give end-to-end latency MUL_LAT cycles uncontended and MUL_LAT+1 for the contention loser.
REQ-024 SHALL keep o_err set until reset.

Reset
REQ-025 SHALL, on i_rst=1, clear pending, hold valid, the FIFO, o_err, o_done_0, o_done_1, o_o_0 and o_o_1, and set rr to requester 0.
REQ-026 SHALL reset the core pipeline with i_rst so that no in-flight result emerges after reset; a mid-operation reset therefore raises no o_err and no done.
REQ-027 SHALL ignore starts while i_rst=1.

Structure
REQ-028 SHALL place the FIELD string constants, requester-ID type and FIFO depth in a shared package.
REQ-029 SHALL contain one sub-module, gf32_mul_core, which wraps gf_mul_32 (GF256) or gf251_mul_32 (P251) by FIELD, is pipelined and has fixed MUL_LAT.

Verification
REQ-030 Bench SHALL cover: single start_0, x=0x00000000, y=0x12345678 -> o_done_0 after MUL_LAT cycles, o_o_0=0, no o_done_1, o_err=0.
REQ-031 Bench SHALL cover: start_0 and start_1 in the same cycle after reset, x_0=0, x_1=nonzero -> o_done_0 at MUL_LAT, o_done_1 at MUL_LAT+1 carrying the core-model product, rr=1 afterwards.
REQ-032 Bench SHALL cover: a second simultaneous pair -> requester 1 wins, requester 0 completes one cycle later.
REQ-033 Bench SHALL cover: i_start_0 repeated while pending -> ignored, single o_done_0, o_err=1 held until reset.
REQ-034 Bench SHALL cover: i_rst one cycle after both starts -> no dones, o_err=0, and a fresh start_1 afterwards completes normally.
REQ-035 Bench SHALL cover: 1000 random legal back-to-back pairs for both FIELD values -> every product matches the gf32_mul_core reference model and is routed to the correct requester.
